c7bexc_ctrl: RTL and testbench
==============================

Name: c7bexc_ctrl

Overview:
- Writeback-stage exception/interrupt commit controller; sits directly upstream of the CSR block.
- Arbitrates the retiring instruction's exception flags, ERTN, and pending interrupts (timer from CSR, synchronized external line) into one commit event per instruction boundary.
- Drives the CSR commit strobes: except, exccode, badv, pc, ertn.
- Issues a registered PC redirect and a pipeline flush window to the front end.

Parameters:
SYNC_STAGES, 2, flops in ext_intr synchronizer (>=2)
DRAIN_CYC, 2, cycles in DRAIN after a commit event (>=1)

Ports:
clk  in  1  core clock
rst  in  1  reset; one clock; reset is synchronous and active-high
ext_intr  in  1  asynchronous external interrupt (HWI0), level
valid_w  in  1  an instruction is retiring in W this cycle
pc_w  in  32  PC of retiring instruction
ale_w  in  1  misaligned access flag
ine_w  in  1  illegal instruction flag
sys_w  in  1  SYSCALL flag
brk_w  in  1  BREAK flag
ertn_w  in  1  ERTN retiring
badv_in_w  in  32  faulting data address (meaningful with ale_w)
csr_crmd_ie  in  1  CRMD.IE
csr_timer_intr  in  1  timer interrupt pending
csr_eentry  in  32  exception entry
csr_era  in  32  exception return address
ext_intr_sync  out  1  synchronized ext_intr, to CSR ESTAT.IS[2]
exu_ifu_except  out  1  exception/interrupt commit strobe
ecl_csr_exccode_w  out  6  exception code
ecl_csr_badv_w  out  32  BADV write value
ifu_exu_pc_w  out  32  ERA write value
ecl_csr_ertn_w  out  1  ERTN commit strobe
redirect_valid  out  1  fetch redirect pulse
redirect_pc  out  32  fetch redirect target
flush  out  1  kill all younger in-flight instructions

Behaviour:
- Synchronizer: SYNC_STAGES flop chain, reset to 0; ext_intr_sync = last stage. Latency is SYNC_STAGES cycles.
- intr_pend = csr_crmd_ie & (csr_timer_intr | ext_intr_sync).
- State machine: IDLE, DRAIN. In DRAIN, all W inputs are ignored (treated as valid_w=0).
- Commit, combinational in IDLE and only when valid_w=1; evaluated in priority order:
  1. intr_pend: except=1, exccode=0x00.
  2. ine_w: except=1, exccode=0x0D.
  3. ale_w: except=1, exccode=0x09.
  4. sys_w: except=1, exccode=0x0B.
  5. brk_w: except=1, exccode=0x0C.
  6. ertn_w: ecl_csr_ertn_w=1.
- An interrupt or exception suppresses ertn in the same cycle.
- exu_ifu_except and ecl_csr_ertn_w are never both 1.
- ifu_exu_pc_w = pc_w at all times.
- ecl_csr_badv_w = badv_in_w when the winning cause is ALE, otherwise pc_w.
- Commit event = except | ertn.
- On a commit event:
  - flush=1 in the same cycle.
  - Next cycle: state=DRAIN, counter=DRAIN_CYC-1, redirect_valid=1 for exactly one cycle.
  - redirect_pc = csr_eentry (exception) or csr_era (ertn), sampled in the commit cycle.
- DRAIN: flush=1 every cycle. When counter=0, return to IDLE next cycle; otherwise decrement. Total flush length = 1 + DRAIN_CYC cycles.
- A new commit cannot occur earlier than DRAIN_CYC+1 cycles after the previous one. This covers the one-cycle CSR update latency of CRMD.IE, so an interrupt cannot retrigger before IE clears.
- valid_w=0 in IDLE: no commit, even with intr_pend. Interrupts are taken only at an instruction boundary.
- Reset values: state=IDLE, counter=0, synchronizer=0, redirect_valid=0, redirect_pc=0, flush=0, exu_ifu_except=0, ecl_csr_ertn_w=0, ecl_csr_exccode_w=0.
- Reset asserted mid-DRAIN: all outputs are 0 the following cycle and the pending redirect is dropped.
- Outputs that are combinational from inputs while rst=1 are gated to 0.

Test Plan:
1. ale_w=1, valid_w=1, pc_w=0x1C000010, badv_in_w=0x00000003, csr_eentry=0x1C008000 -> same cycle: except=1, exccode=0x09, badv=0x00000003, pc=0x1C000010, flush=1. Next cycle: redirect_valid=1, redirect_pc=0x1C008000. flush high for 3 cycles total (DRAIN_CYC=2).
2. csr_crmd_ie=1, csr_timer_intr=1, valid_w=1 together with sys_w=1 and ertn_w=1 -> exccode=0x00, ecl_csr_ertn_w=0, badv=pc_w.
3. ext_intr rises at cycle 0, crmd_ie=1, valid_w=1 every cycle -> ext_intr_sync=1 at cycle 2; commit with exccode=0 at cycle 2; cycles 3-4 no commit while the inputs stay asserted.
4. ertn_w=1, valid_w=1, csr_era=0x1C000200 -> ecl_csr_ertn_w=1, except=0. Next cycle: redirect_pc=0x1C000200.
5. intr_pend=1 with valid_w=0 for 5 cycles -> no commit. Commit occurs in the first cycle valid_w=1.
6. rst=1 during the DRAIN cycle after a commit -> next cycle: redirect_valid=0, flush=0, state=IDLE. A new ine_w commit is accepted immediately after rst deasserts (exccode=0x0D).

Source files
------------

// File: rtl/c7bexc_ctrl_if.sv
// Writeback-stage bus between the retiring instruction/CSR side and the
// exception commit controller, plus the redirect/flush outputs to the front end.
interface c7bexc_ctrl_if;
  logic        valid_w;
  logic [31:0] pc_w;
  logic        ale_w;
  logic        ine_w;
  logic        sys_w;
  logic        brk_w;
  logic        ertn_w;
  logic [31:0] badv_in_w;
  logic        csr_crmd_ie;
  logic        csr_timer_intr;
  logic [31:0] csr_eentry;
  logic [31:0] csr_era;
  logic        exu_ifu_except;
  logic [5:0]  ecl_csr_exccode_w;
  logic [31:0] ecl_csr_badv_w;
  logic [31:0] ifu_exu_pc_w;
  logic        ecl_csr_ertn_w;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        flush;

  modport master (
    output valid_w, pc_w, ale_w, ine_w, sys_w, brk_w, ertn_w, badv_in_w,
           csr_crmd_ie, csr_timer_intr, csr_eentry, csr_era,
    input  exu_ifu_except, ecl_csr_exccode_w, ecl_csr_badv_w, ifu_exu_pc_w,
           ecl_csr_ertn_w, redirect_valid, redirect_pc, flush
  );

  modport slave (
    input  valid_w, pc_w, ale_w, ine_w, sys_w, brk_w, ertn_w, badv_in_w,
           csr_crmd_ie, csr_timer_intr, csr_eentry, csr_era,
    output exu_ifu_except, ecl_csr_exccode_w, ecl_csr_badv_w, ifu_exu_pc_w,
           ecl_csr_ertn_w, redirect_valid, redirect_pc, flush
  );
endinterface

// File: rtl/c7bexc_ctrl.sv
// Writeback exception/interrupt commit controller: picks one commit event per
// instruction boundary, strobes the CSR block and redirects/flushes the front end.
module c7bexc_ctrl #(
  parameter int SYNC_STAGES = 2,
  parameter int DRAIN_CYC   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ext_intr,
  output logic             ext_intr_sync,
  c7bexc_ctrl_if.slave     bus
);

  localparam int CW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  state_t              state_r;
  state_t              state_nxt_s;
  logic [CW-1:0]       cnt_r;
  logic [CW-1:0]       cnt_nxt_s;
  logic [SYNC_STAGES-1:0] sync_r;
  logic                redirect_valid_r;
  logic [31:0]         redirect_pc_r;

  logic                intr_pend_s;
  logic                except_s;
  logic                ertn_s;
  logic                ale_win_s;
  logic [5:0]          exccode_s;
  logic [31:0]         badv_s;
  logic                flush_s;
  logic                commit_s;

  // ext_intr synchronizer chain
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_r <= '0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], ext_intr};
    end
  end

  assign ext_intr_sync = sync_r[SYNC_STAGES-1];
  assign intr_pend_s   = bus.csr_crmd_ie & (bus.csr_timer_intr | ext_intr_sync);
  assign commit_s      = except_s | ertn_s;

  // state register, drain counter and registered redirect
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r          <= IDLE;
      cnt_r            <= '0;
      redirect_valid_r <= 1'b0;
      redirect_pc_r    <= 32'h0000_0000;
    end else begin
      state_r          <= state_nxt_s;
      cnt_r            <= cnt_nxt_s;
      redirect_valid_r <= commit_s;
      if (commit_s) begin
        redirect_pc_r <= except_s ? bus.csr_eentry : bus.csr_era;
      end else begin
        redirect_pc_r <= redirect_pc_r;
      end
    end
  end

  // next-state and drain counter
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      IDLE: begin
        if (commit_s) begin
          state_nxt_s = DRAIN;
          cnt_nxt_s   = CW'(DRAIN_CYC - 1);
        end else begin
          state_nxt_s = IDLE;
        end
      end
      DRAIN: begin
        if (cnt_r == CW'(0)) begin
          state_nxt_s = IDLE;
        end else begin
          cnt_nxt_s = cnt_r - CW'(1);
        end
      end
      default: begin
        state_nxt_s = IDLE;
        cnt_nxt_s   = '0;
      end
    endcase
  end

  // commit arbitration; W inputs are ignored outside IDLE and under reset
  always_comb begin
    except_s  = 1'b0;
    ertn_s    = 1'b0;
    ale_win_s = 1'b0;
    exccode_s = 6'h00;
    if (!rst && (state_r == IDLE) && bus.valid_w) begin
      if (intr_pend_s) begin
        except_s  = 1'b1;
        exccode_s = 6'h00;
      end else if (bus.ine_w) begin
        except_s  = 1'b1;
        exccode_s = 6'h0D;
      end else if (bus.ale_w) begin
        except_s  = 1'b1;
        ale_win_s = 1'b1;
        exccode_s = 6'h09;
      end else if (bus.sys_w) begin
        except_s  = 1'b1;
        exccode_s = 6'h0B;
      end else if (bus.brk_w) begin
        except_s  = 1'b1;
        exccode_s = 6'h0C;
      end else if (bus.ertn_w) begin
        ertn_s = 1'b1;
      end else begin
        ertn_s = 1'b0;
      end
    end else begin
      except_s = 1'b0;
    end

    if (rst) begin
      badv_s  = 32'h0000_0000;
      flush_s = 1'b0;
    end else begin
      badv_s  = ale_win_s ? bus.badv_in_w : bus.pc_w;
      flush_s = except_s | ertn_s | (state_r == DRAIN);
    end
  end

  assign bus.exu_ifu_except    = except_s;
  assign bus.ecl_csr_exccode_w = exccode_s;
  assign bus.ecl_csr_badv_w    = badv_s;
  assign bus.ifu_exu_pc_w      = bus.pc_w;
  assign bus.ecl_csr_ertn_w    = ertn_s;
  assign bus.flush             = flush_s;
  assign bus.redirect_valid    = redirect_valid_r;
  assign bus.redirect_pc       = redirect_pc_r;

endmodule

// File: tb/tb_c7bexc_ctrl.sv
// Bench for c7bexc_ctrl: directed scenarios with literal expectations, then
// random traffic checked every cycle against a cycle-count based model.
module tb_c7bexc_ctrl;
  localparam int SYNC_STAGES = 2;
  localparam int DRAIN_CYC   = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ext_intr = 1'b0;
  logic ext_intr_sync;

  c7bexc_ctrl_if bus ();

  c7bexc_ctrl #(.SYNC_STAGES(SYNC_STAGES), .DRAIN_CYC(DRAIN_CYC)) dut (
    .clk(clk),
    .rst(rst),
    .ext_intr(ext_intr),
    .ext_intr_sync(ext_intr_sync),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h at t=%0t", name, act, exp, $time);
    end
  endtask

  // model state: ext_intr history, cycle of last commit, expected redirect
  bit          ext_q[$];
  int          cyc = 0;
  int          last_commit = -1000;
  logic        m_rv = 1'b0;
  logic [31:0] m_rpc = 32'h0;
  logic        m_commit = 1'b0;
  logic        m_exc = 1'b0;

  // compare process
  always @(negedge clk) begin
    logic ip, drain, live, exc, ert;
    logic [5:0] ecode;
    logic [31:0] ebadv;
    int since;
    since = cyc - last_commit;
    drain = (since >= 1) && (since <= DRAIN_CYC);
    ip    = bus.csr_crmd_ie & (bus.csr_timer_intr | ext_q[0]);
    live  = !rst && !drain && bus.valid_w;
    exc = 1'b0; ert = 1'b0; ecode = 6'h00; ebadv = bus.pc_w;
    if (live) begin
      if (ip)              begin exc = 1'b1; ecode = 6'h00; end
      else if (bus.ine_w)  begin exc = 1'b1; ecode = 6'h0D; end
      else if (bus.ale_w)  begin exc = 1'b1; ecode = 6'h09; ebadv = bus.badv_in_w; end
      else if (bus.sys_w)  begin exc = 1'b1; ecode = 6'h0B; end
      else if (bus.brk_w)  begin exc = 1'b1; ecode = 6'h0C; end
      else if (bus.ertn_w) begin ert = 1'b1; end
    end
    m_commit = exc | ert;
    m_exc    = exc;
    check("sync", 32'(ext_intr_sync), 32'(ext_q[0]));
    check("except", 32'(bus.exu_ifu_except), 32'(exc));
    check("ertn", 32'(bus.ecl_csr_ertn_w), 32'(ert));
    check("exccode", 32'(bus.ecl_csr_exccode_w), 32'(ecode));
    check("flush", 32'(bus.flush), 32'(!rst && (m_commit || drain)));
    check("pc", bus.ifu_exu_pc_w, bus.pc_w);
    if (!rst) check("badv", bus.ecl_csr_badv_w, ebadv);
    check("redir_v", 32'(bus.redirect_valid), 32'(m_rv));
    check("redir_pc", bus.redirect_pc, m_rpc);
  end

  // model update at the clock edge
  always @(posedge clk) begin
    if (rst) begin
      last_commit = -1000;
      m_rv  = 1'b0;
      m_rpc = 32'h0;
      for (int i = 0; i < SYNC_STAGES; i++) ext_q[i] = 1'b0;
    end else begin
      m_rv = m_commit;
      if (m_commit) begin
        last_commit = cyc;
        m_rpc = m_exc ? bus.csr_eentry : bus.csr_era;
      end
      ext_q.push_back(ext_intr);
      void'(ext_q.pop_front());
    end
    cyc++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    bus.valid_w = 1'b0; bus.ale_w = 1'b0; bus.ine_w = 1'b0; bus.sys_w = 1'b0;
    bus.brk_w = 1'b0; bus.ertn_w = 1'b0; bus.csr_crmd_ie = 1'b0;
    bus.csr_timer_intr = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < SYNC_STAGES; i++) ext_q.push_back(1'b0);
    clr();
    bus.pc_w = 32'h0; bus.badv_in_w = 32'h0;
    bus.csr_eentry = 32'h0; bus.csr_era = 32'h0;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rst_redir_v", 32'(bus.redirect_valid), 32'd0);
    check("rst_flush", 32'(bus.flush), 32'd0);
    check("rst_sync", 32'(ext_intr_sync), 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // ALE commit with redirect to EENTRY, 3-cycle flush
    bus.valid_w = 1'b1; bus.ale_w = 1'b1; bus.pc_w = 32'h1C00_0010;
    bus.badv_in_w = 32'h0000_0003; bus.csr_eentry = 32'h1C00_8000;
    @(negedge clk);
    check("t1_except", 32'(bus.exu_ifu_except), 32'd1);
    check("t1_code", 32'(bus.ecl_csr_exccode_w), 32'h09);
    check("t1_badv", bus.ecl_csr_badv_w, 32'h0000_0003);
    check("t1_pc", bus.ifu_exu_pc_w, 32'h1C00_0010);
    check("t1_flush0", 32'(bus.flush), 32'd1);
    tick(); clr();
    @(negedge clk);
    check("t1_rv", 32'(bus.redirect_valid), 32'd1);
    check("t1_rpc", bus.redirect_pc, 32'h1C00_8000);
    check("t1_flush1", 32'(bus.flush), 32'd1);
    tick();
    @(negedge clk);
    check("t1_flush2", 32'(bus.flush), 32'd1);
    check("t1_rv_off", 32'(bus.redirect_valid), 32'd0);
    tick();
    @(negedge clk);
    check("t1_flush3", 32'(bus.flush), 32'd0);
    tick();

    // interrupt beats SYSCALL and ERTN
    bus.csr_crmd_ie = 1'b1; bus.csr_timer_intr = 1'b1; bus.valid_w = 1'b1;
    bus.sys_w = 1'b1; bus.ertn_w = 1'b1; bus.pc_w = 32'h1C00_0020;
    @(negedge clk);
    check("t2_except", 32'(bus.exu_ifu_except), 32'd1);
    check("t2_code", 32'(bus.ecl_csr_exccode_w), 32'h00);
    check("t2_ertn", 32'(bus.ecl_csr_ertn_w), 32'd0);
    check("t2_badv", bus.ecl_csr_badv_w, 32'h1C00_0020);
    tick(); clr(); tick(); tick();

    // ERTN redirects to ERA
    bus.valid_w = 1'b1; bus.ertn_w = 1'b1; bus.csr_era = 32'h1C00_0200;
    @(negedge clk);
    check("t4_ertn", 32'(bus.ecl_csr_ertn_w), 32'd1);
    check("t4_except", 32'(bus.exu_ifu_except), 32'd0);
    tick(); clr();
    @(negedge clk);
    check("t4_rpc", bus.redirect_pc, 32'h1C00_0200);
    tick(); tick();

    // pending interrupt waits for an instruction boundary
    bus.csr_crmd_ie = 1'b1; bus.csr_timer_intr = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t5_hold", 32'(bus.exu_ifu_except), 32'd0);
      tick();
    end
    bus.valid_w = 1'b1;
    @(negedge clk);
    check("t5_take", 32'(bus.exu_ifu_except), 32'd1);
    tick(); clr(); tick(); tick();

    // external interrupt through the synchronizer, no retrigger during drain
    bus.csr_crmd_ie = 1'b1; bus.valid_w = 1'b1; ext_intr = 1'b1;
    @(negedge clk);
    check("t3_c0_sync", 32'(ext_intr_sync), 32'd0);
    tick();
    @(negedge clk);
    check("t3_c1_except", 32'(bus.exu_ifu_except), 32'd0);
    tick();
    @(negedge clk);
    check("t3_c2_sync", 32'(ext_intr_sync), 32'd1);
    check("t3_c2_except", 32'(bus.exu_ifu_except), 32'd1);
    check("t3_c2_code", 32'(bus.ecl_csr_exccode_w), 32'h00);
    tick();
    @(negedge clk);
    check("t3_c3_except", 32'(bus.exu_ifu_except), 32'd0);
    tick();
    @(negedge clk);
    check("t3_c4_except", 32'(bus.exu_ifu_except), 32'd0);
    check("t3_c4_flush", 32'(bus.flush), 32'd1);
    tick(); clr(); ext_intr = 1'b0;
    tick(); tick(); tick();

    // reset in the drain window drops the redirect, then an INE commit
    bus.valid_w = 1'b1; bus.brk_w = 1'b1; bus.pc_w = 32'h1C00_0030;
    @(negedge clk);
    check("t6_code_brk", 32'(bus.ecl_csr_exccode_w), 32'h0C);
    tick(); clr(); rst = 1'b1;
    @(negedge clk);
    check("t6_rst_flush", 32'(bus.flush), 32'd0);
    tick(); rst = 1'b0;
    @(negedge clk);
    check("t6_rv", 32'(bus.redirect_valid), 32'd0);
    check("t6_flush", 32'(bus.flush), 32'd0);
    tick();
    bus.valid_w = 1'b1; bus.ine_w = 1'b1; bus.pc_w = 32'h1C00_0040;
    @(negedge clk);
    check("t6_ine", 32'(bus.exu_ifu_except), 32'd1);
    check("t6_code", 32'(bus.ecl_csr_exccode_w), 32'h0D);
    tick(); clr(); tick(); tick();

    // random traffic, checked by the compare process
    for (int n = 0; n < 3000; n++) begin
      rst                = ($urandom_range(0, 127) == 0);
      bus.valid_w        = $urandom_range(0, 1) == 1;
      bus.ine_w          = $urandom_range(0, 4) == 0;
      bus.ale_w          = $urandom_range(0, 4) == 0;
      bus.sys_w          = $urandom_range(0, 4) == 0;
      bus.brk_w          = $urandom_range(0, 4) == 0;
      bus.ertn_w         = $urandom_range(0, 3) == 0;
      bus.csr_crmd_ie    = $urandom_range(0, 1) == 1;
      bus.csr_timer_intr = $urandom_range(0, 9) == 0;
      if ($urandom_range(0, 19) == 0) ext_intr = ~ext_intr;
      bus.pc_w      = $urandom;
      bus.badv_in_w = $urandom;
      if ($urandom_range(0, 7) == 0) bus.csr_eentry = $urandom;
      if ($urandom_range(0, 7) == 0) bus.csr_era = $urandom;
      tick();
    end
    rst = 1'b0;
    clr();
    tick(); tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
